// File: rtl/fsm_mealy.sv
// rtl/fsm_mealy.sv - three-state Mealy FSM that turns a level input into a one-cycle pulse
// bo fires combinationally in the first cycle bi is seen high after being low.
module fsm_mealy (
   input  logic clk,
   input  logic reset,
   input  logic bi,
   output logic bo
);

   localparam logic [1:0] S_A = 2'b00;
   localparam logic [1:0] S_B = 2'b01;
   localparam logic [1:0] S_C = 2'b10;

   logic [1:0] state_reg;
   logic [1:0] w_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_A;
      end else begin
         state_reg <= w_next;
      end
   end

   // Any low cycle re-arms; the unused encoding 2'b11 falls back to idle.
   always_comb begin
      w_next = S_A;
      case (state_reg)
         S_A:     w_next = bi ? S_B : S_A;
         S_B:     w_next = bi ? S_C : S_A;
         S_C:     w_next = bi ? S_C : S_A;
         default: w_next = S_A;
      endcase
   end

   assign bo = !reset & (state_reg == S_A) & bi;

endmodule

// File: tb/tb_fsm_mealy.sv
// tb/tb_fsm_mealy.sv - directed self-checking bench for fsm_mealy
// Inputs change on the falling edge; outputs are sampled shortly before the rising edge.
`timescale 1ns/1ps
module tb_fsm_mealy;

   logic clk = 1'b0;
   logic reset;
   logic bi;
   logic bo;

   int n_checks = 0;
   int n_errors = 0;

   fsm_mealy dut (
      .clk   (clk),
      .reset (reset),
      .bi    (bi),
      .bo    (bo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive bi on the next falling edge, then sample 4 ns later (1 ns before the rising edge).
   task automatic step(input logic v);
      @(negedge clk);
      bi = v;
      #4;
   endtask

   logic [1:0] held_exp [3];

   initial begin
      held_exp[0] = 2'b01;
      held_exp[1] = 2'b10;
      held_exp[2] = 2'b10;

      reset = 1'b1;
      bi    = 1'b0;

      // 1. reset state, bo suppressed while reset is high even with bi=1
      @(negedge clk);
      #1;
      check("rst_state", dut.state_reg, 2'b00);
      check("rst_bo", {1'b0, bo}, 2'b00);
      bi = 1'b1;
      #1;
      check("rst_bo_bi1", {1'b0, bo}, 2'b00);

      @(negedge clk);
      reset = 1'b0;
      bi    = 1'b0;
      #4;
      check("idle_state", dut.state_reg, 2'b00);
      check("idle_bo", {1'b0, bo}, 2'b00);

      // 2. first cycle of press pulses in the same cycle
      step(1'b1);
      check("press_bo", {1'b0, bo}, 2'b01);
      check("press_state", dut.state_reg, 2'b00);

      // 3. holding bi high walks S_B -> S_C -> S_C with no further pulse
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check($sformatf("hold%0d_state", i), dut.state_reg, held_exp[i]);
         check($sformatf("hold%0d_bo", i), {1'b0, bo}, 2'b00);
      end

      // 4. release from S_C, re-press, release from S_B
      step(1'b0);
      check("relC_bo", {1'b0, bo}, 2'b00);
      step(1'b1);
      check("relC_state", dut.state_reg, 2'b00);
      check("repress_bo", {1'b0, bo}, 2'b01);
      step(1'b0);
      check("relB_state", dut.state_reg, 2'b01);
      check("relB_bo", {1'b0, bo}, 2'b00);
      step(1'b0);
      check("relB_next_state", dut.state_reg, 2'b00);

      // 5. asynchronous reset while in S_C with bi=1
      step(1'b1);
      step(1'b1);
      step(1'b1);
      check("preC_state", dut.state_reg, 2'b10);
      #0.5;
      reset = 1'b1;
      #0.2;
      check("async_rst_state", dut.state_reg, 2'b00);
      check("async_rst_bo", {1'b0, bo}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      bi    = 1'b1;
      #4;
      check("post_rst_bo", {1'b0, bo}, 2'b01);
      check("post_rst_state", dut.state_reg, 2'b00);

      // 6. illegal encoding 2'b11 masks bo and recovers to S_A
      @(negedge clk);
      bi = 1'b1;
      force dut.state_reg = 2'b11;
      #1;
      check("illegal_bo", {1'b0, bo}, 2'b00);
      release dut.state_reg;
      #3;
      check("illegal_bo_rel", {1'b0, bo}, 2'b00);
      @(negedge clk);
      #4;
      check("recover_state", dut.state_reg, 2'b00);
      check("recover_bo", {1'b0, bo}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
